// File: rtl/mna_resp_tx_vc.sv
// Master NoC adapter response path: reassembles two-flit responses from NUM_VC
// virtual channels and replays them on AXI4-Lite R and B channels.

module mna_resp_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         space_next_c
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] left;
  logic             pop;
  logic [W-1:0]     head_n;

  // Occupancy includes the entry presented on the output register; an empty
  // FIFO bypasses the pushed word straight to the output for one-cycle latency.
  always_comb begin
    pop          = valid && ready;
    left         = cnt - CNT_W'(pop);
    cnt_n        = left + CNT_W'(push);
    rd_ptr_n     = rd_ptr + PTR_W'(pop);
    head_n       = (left == '0) ? push_data : mem[rd_ptr_n];
    space_next_c = cnt_n < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr_n;
      cnt    <= cnt_n;
      valid  <= (cnt_n != '0);
      if (cnt_n != '0) begin
        data <= head_n;
      end
    end
  end

endmodule

module mna_resp_tx_vc #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_VC     = 8,
  parameter int unsigned VC_W       = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              is_valid,
  input  logic [VC_W-1:0]   vc_id,
  input  logic              read,
  input  logic [DATA_W-1:0] ubdata,
  output logic [NUM_VC-1:0] is_allocatable,
  output logic [NUM_VC-1:0] is_on_off,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              proto_err
);

  localparam int unsigned RW = DATA_W + 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_n;
  logic [VC_W-1:0]   owner;
  logic [VC_W-1:0]   owner_n;
  logic              is_rd;
  logic              is_rd_n;
  logic [1:0]        code;
  logic [1:0]        code_n;
  logic              accept;
  logic              drop;
  logic              r_push;
  logic              b_push;
  logic              r_space_n;
  logic              b_space_n;
  logic [RW-1:0]     r_data;
  logic [NUM_VC-1:0] on_off_n;
  logic [NUM_VC-1:0] alloc_n;

  always_comb begin
    accept = is_valid && is_on_off[vc_id];
    drop   = is_valid && !is_on_off[vc_id];
  end

  // Packet reassembly: header latches owner/kind/code, payload commits the response.
  always_comb begin
    state_n = state;
    owner_n = owner;
    is_rd_n = is_rd;
    code_n  = code;
    r_push  = 1'b0;
    b_push  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          owner_n = vc_id;
          is_rd_n = read;
          code_n  = ubdata[1:0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          r_push  = is_rd;
          b_push  = !is_rd;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
      owner <= '0;
      is_rd <= 1'b0;
      code  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      is_rd <= is_rd_n;
      code  <= code_n;
    end
  end

  mna_resp_fifo #(
    .W     (RW),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_rfifo (
    .clk          (ACLK),
    .rst_n        (ARESETn),
    .push         (r_push),
    .push_data    ({ubdata, code}),
    .ready        (rready),
    .valid        (rvalid),
    .data         (r_data),
    .space_next_c (r_space_n)
  );

  mna_resp_fifo #(
    .W     (2),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_bfifo (
    .clk          (ACLK),
    .rst_n        (ARESETn),
    .push         (b_push),
    .push_data    (code),
    .ready        (bready),
    .valid        (bvalid),
    .data         (bresp),
    .space_next_c (b_space_n)
  );

  always_comb begin
    rdata = r_data[RW-1:2];
    rresp = r_data[1:0];
  end

  // Flow-control masks are registered from next-cycle state so they match the
  // state and occupancy seen in the cycle they are presented.
  always_comb begin
    on_off_n = '0;
    alloc_n  = '0;
    if (state_n == ST_IDLE) begin
      if (r_space_n && b_space_n) begin
        on_off_n = '1;
        alloc_n  = '1;
      end
    end else begin
      on_off_n = NUM_VC'(1) << owner_n;
    end
  end

  // proto_err pulses in the cycle after the dropped flit.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      is_on_off      <= '0;
      is_allocatable <= '0;
      proto_err      <= 1'b0;
    end else begin
      is_on_off      <= on_off_n;
      is_allocatable <= alloc_n;
      proto_err      <= drop;
    end
  end

endmodule

// File: tb/tb_mna_resp_tx_vc.sv
// Directed bench for mna_resp_tx_vc: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.

module tb_mna_resp_tx_vc;

  logic        ACLK;
  logic        ARESETn;
  logic        is_valid;
  logic [2:0]  vc_id;
  logic        read;
  logic [31:0] ubdata;
  logic [7:0]  is_allocatable;
  logic [7:0]  is_on_off;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        proto_err;

  int n_chk;
  int n_fail;

  mna_resp_tx_vc dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .is_valid       (is_valid),
    .vc_id          (vc_id),
    .read           (read),
    .ubdata         (ubdata),
    .is_allocatable (is_allocatable),
    .is_on_off      (is_on_off),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .bresp          (bresp),
    .bvalid         (bvalid),
    .bready         (bready),
    .proto_err      (proto_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-in-progress flag plus plain response queues.
  bit          m_warm;
  bit          m_in_data;
  int          m_owner;
  bit          m_is_rd;
  logic [1:0]  m_code;
  bit          m_perr;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];

  function automatic logic [7:0] exp_on_off();
    if (!m_warm) return 8'h00;
    if (m_in_data) return 8'h01 << m_owner;
    return (rq.size() < 4 && bq.size() < 4) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [7:0] exp_alloc();
    if (!m_warm || m_in_data) return 8'h00;
    return (rq.size() < 4 && bq.size() < 4) ? 8'hFF : 8'h00;
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_warm = 0; m_in_data = 0; m_owner = 0; m_is_rd = 0; m_code = 2'b00; m_perr = 0;
      rq.delete();
      bq.delete();
    end else begin
      logic [7:0] on;
      bit acc;
      on  = exp_on_off();
      acc = is_valid && on[vc_id];
      m_perr = is_valid && !on[vc_id];
      if (rready && rq.size() > 0) void'(rq.pop_front());
      if (bready && bq.size() > 0) void'(bq.pop_front());
      if (acc) begin
        if (!m_in_data) begin
          m_owner = int'(vc_id); m_is_rd = read; m_code = ubdata[1:0]; m_in_data = 1;
        end else begin
          if (m_is_rd) rq.push_back({ubdata, m_code});
          else bq.push_back(m_code);
          m_in_data = 0;
        end
      end
      m_warm = 1;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_on_off", 64'(is_on_off), 64'd0);
      chk("rst_alloc", 64'(is_allocatable), 64'd0);
      chk("rst_perr", 64'(proto_err), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_resp", 64'({rresp, bresp}), 64'd0);
    end else begin
      chk("on_off", 64'(is_on_off), 64'(exp_on_off()));
      chk("alloc", 64'(is_allocatable), 64'(exp_alloc()));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
      chk("rvalid", 64'(rvalid), 64'(rq.size() > 0));
      chk("bvalid", 64'(bvalid), 64'(bq.size() > 0));
      if (rq.size() > 0) begin
        chk("rdata", 64'(rdata), 64'(rq[0][33:2]));
        chk("rresp", 64'(rresp), 64'(rq[0][1:0]));
      end
      if (bq.size() > 0) chk("bresp", 64'(bresp), 64'(bq[0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic flit(input logic [2:0] vc, input logic rd, input logic [31:0] d);
    is_valid = 1'b1; vc_id = vc; read = rd; ubdata = d;
    cyc(1);
    is_valid = 1'b0; vc_id = 3'd0; read = 1'b0; ubdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    ARESETn = 1'b0; is_valid = 1'b0; vc_id = 3'd0; read = 1'b0; ubdata = 32'd0;
    rready = 1'b0; bready = 1'b0;
    #3;
    chk("lit_rst_alloc", 64'(is_allocatable), 64'h00);
    #19 ARESETn = 1'b1;
    cyc(2);
    chk("lit_idle_alloc", 64'(is_allocatable), 64'hFF);

    // T1 read response with rready already high
    rready = 1'b1;
    flit(3'd2, 1'b1, 32'h0000_0000);
    chk("t1_on_off", 64'(is_on_off), 64'h04);
    chk("t1_alloc", 64'(is_allocatable), 64'h00);
    flit(3'd2, 1'b0, 32'hDEAD_BEEF);
    chk("t1_rvalid", 64'(rvalid), 64'd1);
    chk("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);
    chk("t1_rresp", 64'(rresp), 64'd0);
    cyc(1);
    chk("t1_rvalid_done", 64'(rvalid), 64'd0);
    chk("t1_alloc_after", 64'(is_allocatable), 64'hFF);
    rready = 1'b0;

    // T2 write response held under backpressure
    flit(3'd5, 1'b0, 32'h0000_0002);
    flit(3'd5, 1'b0, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("t2_bvalid_hold", 64'(bvalid), 64'd1);
      chk("t2_bresp_hold", 64'(bresp), 64'd2);
      cyc(1);
    end
    bready = 1'b1;
    cyc(1);
    chk("t2_bvalid_done", 64'(bvalid), 64'd0);
    bready = 1'b0;

    // T3 fill the read FIFO, drop a fifth header, then drain in order
    for (int i = 0; i < 4; i++) begin
      flit(3'd1, 1'b1, 32'(i));
      flit(3'd1, 1'b0, 32'h1000 + 32'(i));
    end
    chk("t3_alloc_full", 64'(is_allocatable), 64'h00);
    chk("t3_on_off_full", 64'(is_on_off), 64'h00);
    flit(3'd1, 1'b1, 32'd0);
    chk("t3_perr", 64'(proto_err), 64'd1);
    cyc(1);
    chk("t3_perr_pulse", 64'(proto_err), 64'd0);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", 64'(rvalid), 64'd1);
      chk("t3_drain_data", 64'(rdata), 64'h1000 + 64'(i));
      chk("t3_drain_resp", 64'(rresp), 64'(i));
      cyc(1);
    end
    chk("t3_empty", 64'(rvalid), 64'd0);
    chk("t3_alloc_back", 64'(is_allocatable), 64'hFF);
    rready = 1'b0;

    // T4 foreign VC during an owned packet
    flit(3'd1, 1'b1, 32'h0000_0001);
    flit(3'd3, 1'b1, 32'h0000_0055);
    chk("t4_perr", 64'(proto_err), 64'd1);
    chk("t4_on_off", 64'(is_on_off), 64'h02);
    flit(3'd1, 1'b0, 32'hCAFE_0001);
    chk("t4_rvalid", 64'(rvalid), 64'd1);
    chk("t4_rdata", 64'(rdata), 64'hCAFE_0001);
    chk("t4_rresp", 64'(rresp), 64'd1);
    rready = 1'b1;
    cyc(1);
    rready = 1'b0;

    // T5 concurrent R/B completion, then push+pop at occupancy two
    flit(3'd0, 1'b0, 32'h0000_0003);
    flit(3'd0, 1'b0, 32'h0000_0000);
    flit(3'd4, 1'b1, 32'h0000_0002);
    flit(3'd4, 1'b0, 32'h0000_A5A5);
    chk("t5_both_valid", 64'({rvalid, bvalid}), 64'b11);
    chk("t5_bresp", 64'(bresp), 64'd3);
    rready = 1'b1; bready = 1'b1;
    cyc(1);
    chk("t5_both_done", 64'({rvalid, bvalid}), 64'b00);
    rready = 1'b0; bready = 1'b0;
    flit(3'd6, 1'b1, 32'd0);
    flit(3'd6, 1'b0, 32'h11);
    flit(3'd6, 1'b1, 32'd0);
    flit(3'd6, 1'b0, 32'h22);
    flit(3'd6, 1'b1, 32'd0);
    rready = 1'b1;
    flit(3'd6, 1'b0, 32'h33);
    rready = 1'b0;
    chk("t5_pp_data", 64'(rdata), 64'h22);
    rready = 1'b1;
    cyc(1);
    chk("t5_pp_next", 64'(rdata), 64'h33);
    cyc(1);
    chk("t5_pp_empty", 64'(rvalid), 64'd0);
    rready = 1'b0;

    // T6 reset with two queued reads and a packet in progress
    flit(3'd2, 1'b1, 32'd0);
    flit(3'd2, 1'b0, 32'h77);
    flit(3'd2, 1'b1, 32'd0);
    flit(3'd2, 1'b0, 32'h88);
    flit(3'd2, 1'b1, 32'd0);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_rvalid_async", 64'(rvalid), 64'd0);
    chk("t6_on_off_async", 64'(is_on_off), 64'd0);
    cyc(2);
    ARESETn = 1'b1;
    cyc(2);
    chk("t6_idle_alloc", 64'(is_allocatable), 64'hFF);
    chk("t6_fifo_empty", 64'(rvalid), 64'd0);
    flit(3'd6, 1'b1, 32'd0);
    flit(3'd6, 1'b0, 32'h99);
    chk("t6_after_rdata", 64'(rdata), 64'h99);
    chk("t6_after_rvalid", 64'(rvalid), 64'd1);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
